// File: rtl/ama_riscv_rf_wb_arbiter_if.sv
// Writeback bus between the pipeline/MC unit (master) and the register-file
// writeback arbiter (slave).
interface ama_riscv_rf_wb_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_addr;
  logic [31:0] mc_data;
  logic        mc_issue;
  logic [4:0]  mc_issue_addr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_addr_d;
  logic [31:0] rf_data_d;

  modport slave (
    input  pipe_we, pipe_addr, pipe_data,
    input  mc_valid, mc_addr, mc_data, mc_issue, mc_issue_addr,
    input  rs1_addr, rs2_addr,
    output mc_ready, rs1_busy, rs2_busy, stall_req,
    output rf_we, rf_addr_d, rf_data_d
  );

  modport master (
    output pipe_we, pipe_addr, pipe_data,
    output mc_valid, mc_addr, mc_data, mc_issue, mc_issue_addr,
    output rs1_addr, rs2_addr,
    input  mc_ready, rs1_busy, rs2_busy, stall_req,
    input  rf_we, rf_addr_d, rf_data_d
  );
endinterface

// File: rtl/ama_riscv_rf_wb_arbiter.sv
// Register-file writeback arbiter between the pipeline and a multi-cycle unit,
// with starvation escape; busy scoreboard present when AMA_RISCV_RF_SCOREBOARD_EN is defined.
module ama_riscv_rf_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  ama_riscv_rf_wb_arbiter_if.slave      bus
);

  typedef enum logic {PIPE_PRI = 1'b0, MC_PRI = 1'b1} state_t;

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

  state_t      state_q;
  logic [3:0]  starve_q;
  logic        rf_we_q;
  logic [4:0]  rf_addr_q;
  logic [31:0] rf_data_q;

  logic        mc_ready;
  logic        mc_hs;
  logic        grant_mc;
  logic        grant_pipe;
  logic        blocked;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  always_comb begin
    mc_ready   = !rst && (state_q == MC_PRI || !bus.pipe_we);
    mc_hs      = bus.mc_valid && mc_ready;
    // In MC_PRI a pipeline write colliding with a valid MC write is dropped.
    grant_mc   = (state_q == MC_PRI && bus.mc_valid) || (!bus.pipe_we && mc_hs);
    grant_pipe = bus.pipe_we && !(state_q == MC_PRI && bus.mc_valid);
    blocked    = (state_q == PIPE_PRI) && bus.mc_valid && !mc_ready;
    wb_addr    = grant_mc ? bus.mc_addr : bus.pipe_addr;
    wb_data    = grant_mc ? bus.mc_data : bus.pipe_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PIPE_PRI;
      starve_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      rf_we_q <= (grant_mc || grant_pipe) && (wb_addr != 5'd0);
      if (grant_mc || grant_pipe) begin
        rf_addr_q <= wb_addr;
        rf_data_q <= wb_data;
      end
      case (state_q)
        PIPE_PRI: begin
          if (blocked) begin
            starve_q <= starve_q + 4'd1;
            if (starve_q == STARVE_LAST) state_q <= MC_PRI;
          end else begin
            starve_q <= '0;
          end
        end
        MC_PRI: begin
          if (mc_hs || !bus.mc_valid) begin
            state_q  <= PIPE_PRI;
            starve_q <= '0;
          end
        end
        default: begin
          state_q  <= PIPE_PRI;
          starve_q <= '0;
        end
      endcase
    end
  end

  assign bus.mc_ready  = mc_ready;
  assign bus.stall_req = !rst && (state_q == MC_PRI);
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_addr_d = rf_addr_q;
  assign bus.rf_data_d = rf_data_q;

`ifdef AMA_RISCV_RF_SCOREBOARD_EN
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // Set is applied after clear so a same-cycle issue/retire keeps the bit.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.mc_issue) set_mask[bus.mc_issue_addr] = 1'b1;
    if (mc_hs)        clr_mask[bus.mc_addr]       = 1'b1;
    busy_d = ((busy_q & ~clr_mask) | set_mask) & ~32'h1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign bus.rs1_busy = busy_q[bus.rs1_addr];
  assign bus.rs2_busy = busy_q[bus.rs2_addr];
`else
  assign bus.rs1_busy = 1'b0;
  assign bus.rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_ama_riscv_rf_wb_arbiter.sv
// Directed bench for ama_riscv_rf_wb_arbiter (STARVE_LIMIT=4); scoreboard
// expectations follow AMA_RISCV_RF_SCOREBOARD_EN.
module tb_ama_riscv_rf_wb_arbiter;

`ifdef AMA_RISCV_RF_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ama_riscv_rf_wb_arbiter_if bus ();

  ama_riscv_rf_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_we = 1'b0; bus.pipe_addr = '0; bus.pipe_data = '0;
    bus.mc_valid = 1'b0; bus.mc_addr = '0; bus.mc_data = '0;
    bus.mc_issue = 1'b0; bus.mc_issue_addr = '0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    idle();
    bus.rs1_addr = 5'd9;
    bus.rs2_addr = 5'd0;
    tick();
    tick();
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_rf_addr", 32'(bus.rf_addr_d), 32'd0);
    chk("rst_rf_data", bus.rf_data_d, 32'd0);
    chk("rst_mc_ready", 32'(bus.mc_ready), 32'd0);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    chk("rst_rs1_busy", 32'(bus.rs1_busy), 32'd0);

    rst = 1'b0;
    #1;
    chk("idle_mc_ready", 32'(bus.mc_ready), 32'd1);

    // pipeline write
    bus.pipe_we = 1'b1; bus.pipe_addr = 5'd5; bus.pipe_data = 32'hDEADBEEF;
    #1;
    chk("pipe_mc_ready", 32'(bus.mc_ready), 32'd0);
    tick();
    idle();
    chk("pipe_rf_we", 32'(bus.rf_we), 32'd1);
    chk("pipe_rf_addr", 32'(bus.rf_addr_d), 32'd5);
    chk("pipe_rf_data", bus.rf_data_d, 32'hDEADBEEF);

    // MC write with pipeline idle
    bus.mc_valid = 1'b1; bus.mc_addr = 5'd7; bus.mc_data = 32'h12345678;
    #1;
    chk("mc_ready", 32'(bus.mc_ready), 32'd1);
    tick();
    idle();
    chk("mc_rf_we", 32'(bus.rf_we), 32'd1);
    chk("mc_rf_addr", 32'(bus.rf_addr_d), 32'd7);
    chk("mc_rf_data", bus.rf_data_d, 32'h12345678);
    tick();
    chk("nogrant_rf_we", 32'(bus.rf_we), 32'd0);

    // writes to x0 suppressed
    bus.pipe_we = 1'b1; bus.pipe_addr = 5'd0; bus.pipe_data = 32'hFFFFFFFF;
    tick();
    idle();
    chk("pipe_x0_rf_we", 32'(bus.rf_we), 32'd0);
    bus.mc_valid = 1'b1; bus.mc_addr = 5'd0; bus.mc_data = 32'hCAFEF00D;
    #1;
    chk("mc_x0_ready", 32'(bus.mc_ready), 32'd1);
    tick();
    idle();
    chk("mc_x0_rf_we", 32'(bus.rf_we), 32'd0);

    // starvation escape: both held high
    bus.mc_valid = 1'b1; bus.mc_addr = 5'd10; bus.mc_data = 32'hAA;
    bus.pipe_we = 1'b1; bus.pipe_addr = 5'd3;
    for (int c = 1; c <= 6; c++) begin
      bus.pipe_data = 32'(c);
      #1;
      chk($sformatf("starve_stall_c%0d", c), 32'(bus.stall_req), 32'(c == 5));
      chk($sformatf("starve_ready_c%0d", c), 32'(bus.mc_ready), 32'(c == 5));
      tick();
      chk($sformatf("starve_rf_we_c%0d", c), 32'(bus.rf_we), 32'd1);
      chk($sformatf("starve_addr_c%0d", c), 32'(bus.rf_addr_d), (c == 5) ? 32'd10 : 32'd3);
      chk($sformatf("starve_data_c%0d", c), bus.rf_data_d, (c == 5) ? 32'hAA : 32'(c));
    end
    idle();
    tick();

    // MC_PRI with mc_valid dropped: pipeline is granted
    bus.mc_valid = 1'b1; bus.mc_addr = 5'd11; bus.pipe_we = 1'b1; bus.pipe_addr = 5'd3;
    repeat (4) tick();
    bus.mc_valid = 1'b0; bus.pipe_addr = 5'd4; bus.pipe_data = 32'h44;
    #1;
    chk("mcpri_noval_stall", 32'(bus.stall_req), 32'd1);
    chk("mcpri_noval_ready", 32'(bus.mc_ready), 32'd1);
    tick();
    idle();
    chk("mcpri_noval_rf_we", 32'(bus.rf_we), 32'd1);
    chk("mcpri_noval_addr", 32'(bus.rf_addr_d), 32'd4);
    chk("mcpri_noval_data", bus.rf_data_d, 32'h44);
    #1;
    chk("mcpri_exit_stall", 32'(bus.stall_req), 32'd0);

    // scoreboard
    bus.rs1_addr = 5'd9; bus.rs2_addr = 5'd9;
    bus.mc_issue = 1'b1; bus.mc_issue_addr = 5'd9;
    #1;
    chk("sb_no_bypass", 32'(bus.rs1_busy), 32'd0);
    tick();
    idle();
    chk("sb_issue_rs1", 32'(bus.rs1_busy), 32'(SB));
    chk("sb_issue_rs2", 32'(bus.rs2_busy), 32'(SB));
    bus.mc_issue = 1'b1; bus.mc_issue_addr = 5'd9;
    bus.mc_valid = 1'b1; bus.mc_addr = 5'd9; bus.mc_data = 32'h99;
    tick();
    idle();
    chk("sb_set_wins", 32'(bus.rs1_busy), 32'(SB));
    chk("sb_set_wins_wb", 32'(bus.rf_addr_d), 32'd9);
    bus.mc_valid = 1'b1; bus.mc_addr = 5'd9;
    tick();
    idle();
    chk("sb_retire", 32'(bus.rs1_busy), 32'd0);
    bus.mc_issue = 1'b1; bus.mc_issue_addr = 5'd0; bus.rs2_addr = 5'd0;
    tick();
    idle();
    chk("sb_x0", 32'(bus.rs2_busy), 32'd0);

    // reset in MC_PRI with counter nonzero and a busy bit set
    bus.mc_issue = 1'b1; bus.mc_issue_addr = 5'd9;
    tick();
    idle();
    chk("sb_pre_rst", 32'(bus.rs1_busy), 32'(SB));
    bus.mc_valid = 1'b1; bus.mc_addr = 5'd12; bus.pipe_we = 1'b1; bus.pipe_addr = 5'd3;
    bus.pipe_data = 32'h33;
    repeat (4) tick();
    chk("pre_rst_stall", 32'(bus.stall_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst2_mc_ready", 32'(bus.mc_ready), 32'd0);
    chk("rst2_stall", 32'(bus.stall_req), 32'd0);
    tick();
    chk("rst2_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst2_rf_addr", 32'(bus.rf_addr_d), 32'd0);
    chk("rst2_rf_data", bus.rf_data_d, 32'd0);
    chk("rst2_rs1_busy", 32'(bus.rs1_busy), 32'd0);
    rst = 1'b0;
    idle();
    tick();
    chk("post_rst_stall", 32'(bus.stall_req), 32'd0);
    chk("post_rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("post_rst_rs1_busy", 32'(bus.rs1_busy), 32'd0);
    bus.mc_valid = 1'b1; bus.mc_addr = 5'd12; bus.pipe_we = 1'b1; bus.pipe_addr = 5'd3;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("post_rst_starve_c%0d", c), 32'(bus.stall_req), 32'(c == 5));
      tick();
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ama_riscv_rf_wb_arbiter.md
AMA_RISCV_RF_WB_ARBITER -- requirements
Module: ama_riscv_rf_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, number of consecutive blocked multi-cycle (MC) cycles before forced MC priority; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 pipe_we  in  1  pipeline writeback request (no backpressure).
REQ-005 pipe_addr  in  5  pipeline destination register.
REQ-006 pipe_data  in  32  pipeline writeback data.
REQ-007 mc_valid  in  1  MC unit writeback valid.
REQ-008 mc_ready  out  1  MC writeback accepted this cycle (combinational).
REQ-009 mc_addr  in  5  MC destination register.
REQ-010 mc_data  in  32  MC writeback data.
REQ-011 mc_issue  in  1  MC operation issued this cycle (scoreboard set).
REQ-012 mc_issue_addr  in  5  destination of issued MC operation.
REQ-013 rs1_addr, rs2_addr  in  5 each  scoreboard query addresses.
REQ-014 rs1_busy, rs2_busy  out  1 each  query register has a pending MC write (combinational from busy register).
REQ-015 stall_req  out  1  pipeline must not present pipe_we next cycle while high.
REQ-016 rf_we, rf_addr_d, rf_data_d  out  1/5/32  registered register-file write port (drives we/addr_d/data_d).

Function
REQ-017 FSM states PIPE_PRI (pipeline wins) and MC_PRI (MC wins); stall_req = (state == MC_PRI).
REQ-018 mc_ready = !rst && (state == MC_PRI || !pipe_we); MC handshake = mc_valid && mc_ready.
REQ-019 Grant: MC_PRI with mc_valid -> MC; else pipe_we -> pipeline; else MC handshake -> MC; else none.
REQ-020 Granted write registered: rf_we/rf_addr_d/rf_data_d update one cycle after grant; rf_we=0 when no grant.
REQ-021 Grant with destination x0 completes any handshake but drives rf_we=0 for that cycle.
REQ-022 pipe_we asserted during MC_PRI while mc_valid=1 is dropped (protocol violation); if mc_valid=0 in MC_PRI, pipeline write granted.
REQ-023 Starve counter (4 bits) increments each PIPE_PRI cycle with mc_valid && !mc_ready; clears on MC handshake or mc_valid=0.
REQ-024 PIPE_PRI -> MC_PRI on a blocked cycle when counter == STARVE_LIMIT-1 (i.e. after STARVE_LIMIT blocked cycles).
REQ-025 MC_PRI -> PIPE_PRI on MC handshake or when mc_valid=0; counter cleared on exit.
REQ-026 Scoreboard: 32 busy bits; mc_issue sets bit mc_issue_addr, MC handshake clears bit mc_addr, both effective next cycle.
REQ-027 Simultaneous set and clear of the same bit: set wins (bit stays 1); busy[0] is constant 0.
REQ-028 rsN_busy reflects registered busy bits only (no same-cycle bypass of issue/retire).

Reset
REQ-029 While rst=1: state=PIPE_PRI, counter=0, all busy bits=0, rf_we=0, rf_addr_d=0, rf_data_d=0, mc_ready=0, stall_req=0.
REQ-030 Reset mid-operation discards any in-flight grant; first write after rst deasserts appears no earlier than the second posedge.

Configuration
REQ-031 Macro AMA_RISCV_RF_SCOREBOARD_EN: defined -> scoreboard per REQ-026..028 present; undefined -> no busy storage, rs1_busy=rs2_busy=0 constantly, mc_issue/mc_issue_addr ignored, all other behaviour unchanged.

Verification
REQ-032 pipe_we=1, addr=5, data=0xDEADBEEF, mc idle -> next cycle rf_we=1, rf_addr_d=5, rf_data_d=0xDEADBEEF; mc_ready=0 that cycle.
REQ-033 mc_valid=1 addr=7 data=0x12345678, pipe_we=0 -> mc_ready=1 same cycle; next cycle rf_we=1, rf_addr_d=7.
REQ-034 STARVE_LIMIT=4, mc_valid and pipe_we held high -> cycles 1-4 pipeline granted, stall_req=1 from cycle 5, MC granted cycle 5, PIPE_PRI restored cycle 6.
REQ-035 pipe_we=1 addr=0 data=0xFFFFFFFF -> rf_we stays 0; MC handshake to x0 -> mc_ready=1, rf_we stays 0.
REQ-036 Scoreboard (macro defined): issue x9 -> rs1_addr=9 gives rs1_busy=1 next cycle; issue x9 and retire x9 same cycle -> stays 1; retire alone -> 0 next cycle; macro undefined -> always 0.
REQ-037 rst asserted one cycle in MC_PRI with counter nonzero -> all outputs zero during rst, state PIPE_PRI and busy bits clear afterwards.
